lab4_fir_seq: RTL



---
 rtl/lab4_fir_seq_if.sv | 28 ++
 rtl/lab4_fir_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/lab4_fir_seq_if.sv
// Streaming sample interface for lab4_fir_seq: sample input handshake and result output handshake.
// The master drives samples and sink readiness; the slave is the filter block.
interface lab4_fir_seq_if;
  logic       in_valid;
  logic       in_ready;
  logic [9:0] in_sample;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_y;

  modport master (
    output in_valid,
    output in_sample,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_y
  );

  modport slave (
    input  in_valid,
    input  in_sample,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_y
  );
endinterface

// File: rtl/lab4_fir_seq.sv
// Three-tap FIR, y = K1*x1 + K2*x2 + K3*x3, evaluated over three cycles on one shared multiplier.
// Bit-exact with the combinational lab 4 datapath: 1.9 samples, 1.11 coefficients, 12-bit wrapping sum.
module lab4_fir_seq #(
  parameter logic signed [11:0] K1 = 12'shC00,
  parameter logic signed [11:0] K2 = 12'sh500,
  parameter logic signed [11:0] K3 = 12'shC00
) (
  input logic           clk,
  input logic           rst_n,
  lab4_fir_seq_if.slave bus
);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StMac1 = 3'd1;
  localparam logic [2:0] StMac2 = 3'd2;
  localparam logic [2:0] StMac3 = 3'd3;
  localparam logic [2:0] StOut  = 3'd4;

  logic [2:0]         state_q, state_d;
  logic signed [9:0]  d0_q, d0_d;
  logic signed [9:0]  d1_q, d1_d;
  logic signed [9:0]  d2_q, d2_d;
  logic signed [11:0] acc_q, acc_d;
  logic [9:0]         out_y_q, out_y_d;

  logic               accept;
  logic signed [9:0]  mul_x;
  logic signed [11:0] mul_k;
  logic signed [11:0] mul_v;
  logic signed [23:0] mul_t;
  logic signed [11:0] tap_p;
  logic signed [11:0] acc_sum;
  logic               unused_bits;

  assign accept = bus.in_valid && (state_q == StIdle);

  // Operand mux: each MAC state picks its tap and coefficient.
  always_comb begin
    mul_x = '0;
    mul_k = '0;
    case (state_q)
      StMac1:  begin mul_x = d0_q; mul_k = K1; end
      StMac2:  begin mul_x = d1_q; mul_k = K2; end
      StMac3:  begin mul_x = d2_q; mul_k = K3; end
      default: begin mul_x = '0;   mul_k = '0; end
    endcase
  end

  assign mul_v   = {mul_x, 2'b00};
  assign mul_t   = 24'(mul_v) * 24'(mul_k);
  assign tap_p   = mul_t[22:11];
  assign acc_sum = acc_q + tap_p;

  // Bits dropped by the fixed-point scaling and the final truncation.
  assign unused_bits = ^{mul_t[23], mul_t[10:0], acc_sum[1:0]};

  always_comb begin
    state_d = state_q;
    d0_d    = d0_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    acc_d   = acc_q;
    out_y_d = out_y_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          d2_d    = d1_q;
          d1_d    = d0_q;
          d0_d    = bus.in_sample;
          state_d = StMac1;
        end
      end
      StMac1: begin
        acc_d   = tap_p;
        state_d = StMac2;
      end
      StMac2: begin
        acc_d   = acc_sum;
        state_d = StMac3;
      end
      StMac3: begin
        acc_d   = acc_sum;
        out_y_d = acc_sum[11:2];
        state_d = StOut;
      end
      StOut: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      d0_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      acc_q   <= '0;
      out_y_q <= '0;
    end else begin
      state_q <= state_d;
      d0_q    <= d0_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      acc_q   <= acc_d;
      out_y_q <= out_y_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_y     = out_y_q;

  // A stalled result must hold, and the delay line only moves on an accepted sample.
  a_stall_hold : assert property (@(posedge clk) disable iff (!rst_n)
    (bus.out_valid && !bus.out_ready) |=> (bus.out_valid && $stable(bus.out_y)));

  a_busy_no_shift : assert property (@(posedge clk) disable iff (!rst_n)
    !bus.in_ready |=> ($stable(d0_q) && $stable(d1_q) && $stable(d2_q)));

endmodule
